// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//   Shared constants and helpers for the register-file write-back arbiter.
//   Holds the default requester count and bus widths, the requester
//   identities (ALU, LSU, MDU), the register-0 address and a pointer-width
//   helper used by the top and the grant sub-module.
package regfile_wb_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_id_e;

  // Writes to register 0 are accepted but never reach the register file.
  localparam logic [ADDR_W-1:0] REG_ZERO_ADDR = '0;

  // Width of the round-robin pointer; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Write-back request bus between the requesters and the arbiter, plus the
//   register-file write port driven by the arbiter.
//   Signals:
//     Stall_WB  - blocks all grants in the current cycle
//     Req_Valid - per-requester write request
//     Req_Addr  - packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
//     Req_Data  - packed write data, requester i at [i*DATA_W +: DATA_W]
//     Req_Ready - one-hot grant (or zero), combinational
//     WrEn_RF / WAddr_RF / WD_RF - registered register-file write port
//   Modports: master (requester / pipeline side), slave (arbiter).
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = regfile_wb_arbiter_pkg::DATA_W
) ();
  import regfile_wb_arbiter_pkg::*;

  logic                       Stall_WB;
  logic [NUM_REQ-1:0]         Req_Valid;
  logic [NUM_REQ*ADDR_W-1:0]  Req_Addr;
  logic [NUM_REQ*DATA_W-1:0]  Req_Data;
  logic [NUM_REQ-1:0]         Req_Ready;
  logic                       WrEn_RF;
  logic [ADDR_W-1:0]          WAddr_RF;
  logic [DATA_W-1:0]          WD_RF;

  modport master (
    output Stall_WB, Req_Valid, Req_Addr, Req_Data,
    input  Req_Ready, WrEn_RF, WAddr_RF, WD_RF
  );

  modport slave (
    input  Stall_WB, Req_Valid, Req_Addr, Req_Data,
    output Req_Ready, WrEn_RF, WAddr_RF, WD_RF
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_rr_arbiter.sv
// wb_rr_arbiter
//   Purely combinational grant selection. Scans requesters starting at the
//   priority pointer and wrapping modulo NUM_REQ; the first valid requester
//   found receives the single grant bit.
//   Ports:
//     valid - per-requester request vector
//     ptr   - index of the highest-priority requester (0..NUM_REQ-1)
//     grant - one-hot grant, zero when nothing is valid
module wb_rr_arbiter #(
  parameter int NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int PTR_W   = regfile_wb_arbiter_pkg::ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  import regfile_wb_arbiter_pkg::*;

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates NUM_REQ write-back requesters onto one register-file write
//   port. Grants are combinational (Req_Ready); the accepted address/data
//   appear on the register-file port exactly one cycle later. Writes to
//   register 0 are accepted but produce WrEn_RF=0.
//   Priority is round-robin (pointer advances past each grant) unless the
//   macro WB_FIXED_PRIO_EN is defined, which selects fixed priority with
//   requester 0 highest and no pointer state.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-low; clears the write port and pointer
//     bus   - regfile_wb_arbiter_if.slave (request bus + register-file port)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = regfile_wb_arbiter_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  import regfile_wb_arbiter_pkg::*;

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [PTR_W-1:0]   ptr;

  logic               vld_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  data_p0;

  logic               wren_p1;
  logic [ADDR_W-1:0]  waddr_p1;
  logic [DATA_W-1:0]  wd_p1;

  wb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_grant (
    .valid (bus.Req_Valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Reset is used combinationally here so no grant is visible while it is low.
  assign ready         = (reset && !bus.Stall_WB) ? grant : '0;
  assign bus.Req_Ready = ready;

  // ---- Stage p0: accepted request (grant is one-hot, so at most one hit) ----
  always_comb begin
    vld_p0  = 1'b0;
    addr_p0 = '0;
    data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        vld_p0  = 1'b1;
        addr_p0 = bus.Req_Addr[i*ADDR_W +: ADDR_W];
        data_p0 = bus.Req_Data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at requester 0.
  assign ptr = '0;
`else
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] ptr_q;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i]) begin
        sel_idx = PTR_W'(i);
      end
    end
  end

  // Pointer moves just past the granted requester, wrapping to 0 after the last.
  always_comb begin
    ptr_nxt = ptr_q;
    if (vld_p0) begin
      if (int'(sel_idx) == NUM_REQ - 1) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = sel_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end

  assign ptr = ptr_q;
`endif

  // ---- Stage p1: registered register-file write port ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wren_p1  <= 1'b0;
      waddr_p1 <= '0;
      wd_p1    <= '0;
    end else begin
      wren_p1 <= vld_p0 && (addr_p0 != ADDR_W'(REG_ZERO_ADDR));
      if (vld_p0) begin
        waddr_p1 <= addr_p0;
        wd_p1    <= data_p0;
      end
    end
  end

  assign bus.WrEn_RF  = wren_p1;
  assign bus.WAddr_RF = waddr_p1;
  assign bus.WD_RF    = wd_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Scoreboard bench for regfile_wb_arbiter. Each cycle the bench predicts
//   the grant and the next-cycle write port from its own priority model,
//   pushes the expected write into a queue, and pops it after the clock edge.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  int            ptr_m;
  logic [AW-1:0] last_addr_m;
  logic [DW-1:0] last_data_m;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] mode_sel(input logic [NR-1:0] rr, input logic [NR-1:0] fx);
`ifdef WB_FIXED_PRIO_EN
    return fx;
`else
    return rr;
`endif
  endfunction

  task automatic model_reset();
    ptr_m       = 0;
    last_addr_m = '0;
    last_data_m = '0;
    sb.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Req_Addr[i*AW +: AW] = a;
    bus.Req_Data[i*DW +: DW] = d;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next
  // falling edge with the write port of this cycle's acceptance visible.
  task automatic run_cycle(output logic [NR-1:0] rdy);
    int            gi;
    logic [NR-1:0] g;
    exp_t          e;
    #1;
    gi = -1;
    g  = '0;
    if (!bus.Stall_WB) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (ptr_m + k) % NR;
        if (gi < 0 && bus.Req_Valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    check("ready", 64'(bus.Req_Ready), 64'(g));
    rdy = bus.Req_Ready;
    if (gi >= 0) begin
      last_addr_m = bus.Req_Addr[gi*AW +: AW];
      last_data_m = bus.Req_Data[gi*DW +: DW];
      e.wren = (last_addr_m != '0);
`ifndef WB_FIXED_PRIO_EN
      ptr_m = (gi + 1) % NR;
`endif
    end else begin
      e.wren = 1'b0;
    end
    e.addr = last_addr_m;
    e.data = last_data_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      check("wren", 64'(bus.WrEn_RF), 64'(e.wren));
      check("waddr", 64'(bus.WAddr_RF), 64'(e.addr));
      check("wd", 64'(bus.WD_RF), 64'(e.data));
    end
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks the write port clears at once.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_wren"},  64'(bus.WrEn_RF), 64'(0));
    check({tag, "_waddr"}, 64'(bus.WAddr_RF), 64'(0));
    check({tag, "_wd"},    64'(bus.WD_RF), 64'(0));
    check({tag, "_ready"}, 64'(bus.Req_Ready), 64'(0));
    @(posedge clk);
    #1;
    check({tag, "_hold_wren"}, 64'(bus.WrEn_RF), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  logic [NR-1:0] r;
  logic [NR-1:0] ord_rr [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    reset = 1'b0;
    bus.Stall_WB  = 1'b0;
    bus.Req_Valid = 3'b111;
    bus.Req_Addr  = '0;
    bus.Req_Data  = '0;
    set_req(0, 5'd3,  32'h0000_0A00);
    set_req(1, 5'd9,  32'h0000_0B11);
    set_req(2, 5'd17, 32'h0000_0C22);
    #3;
    check("rst_wren",  64'(bus.WrEn_RF), 64'(0));
    check("rst_waddr", 64'(bus.WAddr_RF), 64'(0));
    check("rst_wd",    64'(bus.WD_RF), 64'(0));
    check("rst_ready", 64'(bus.Req_Ready), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Short stream, then reset in the middle of it.
    repeat (2) run_cycle(r);
    do_reset("midrst");

    // Single request from requester 0.
    bus.Req_Valid = 3'b001;
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    run_cycle(r);
    check("single_ready", 64'(r), 64'(3'b001));
    check("single_wren",  64'(bus.WrEn_RF), 64'(1));
    check("single_waddr", 64'(bus.WAddr_RF), 64'(5));
    check("single_wd",    64'(bus.WD_RF), 64'(32'hDEAD_BEEF));
    bus.Req_Valid = 3'b011;
    set_req(0, 5'd3, 32'h0000_0A00);
    run_cycle(r);
    check("ptr_after_0", 64'(r), 64'(mode_sel(3'b010, 3'b001)));

    // Bring the pointer back to 0 with a grant to requester 2.
    bus.Req_Valid = 3'b100;
    run_cycle(r);

    // All valid for six cycles: full rotation twice.
    ord_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    bus.Req_Valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      run_cycle(r);
      check($sformatf("rot%0d_ready", k), 64'(r), 64'(mode_sel(ord_rr[k], 3'b001)));
      check($sformatf("rot%0d_wren", k), 64'(bus.WrEn_RF), 64'(1));
    end

    // Address-0 write: accepted, pointer advances, no register-file write.
    bus.Req_Valid = 3'b010;
    set_req(1, 5'd0, 32'h0000_1234);
    run_cycle(r);
    check("zero_ready", 64'(r), 64'(3'b010));
    check("zero_wren",  64'(bus.WrEn_RF), 64'(0));
    bus.Req_Valid = 3'b111;
    set_req(1, 5'd9, 32'h0000_0B11);
    run_cycle(r);
    check("zero_ptr", 64'(r), 64'(mode_sel(3'b100, 3'b001)));

    // Stall for two cycles, then release.
    bus.Req_Valid = 3'b011;
    bus.Stall_WB  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_cycle(r);
      check($sformatf("stall%0d_ready", k), 64'(r), 64'(0));
      check($sformatf("stall%0d_wren", k), 64'(bus.WrEn_RF), 64'(0));
    end
    bus.Stall_WB = 1'b0;
    run_cycle(r);
    check("post_stall0", 64'(r), 64'(3'b001));
    bus.Req_Valid = 3'b010;
    run_cycle(r);
    check("post_stall1", 64'(r), 64'(3'b010));

    // Random traffic checked against the model.
    for (int k = 0; k < 60; k++) begin
      bus.Req_Valid = NR'($urandom_range(0, 7));
      bus.Stall_WB  = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NR; i++) begin
        set_req(i, AW'($urandom_range(0, 31)), $urandom());
      end
      run_cycle(r);
    end
    bus.Stall_WB  = 1'b0;
    bus.Req_Valid = 3'b000;
    run_cycle(r);

    // Acceptance in flight when reset asserts is discarded.
    bus.Req_Valid = 3'b001;
    set_req(0, 5'd7, 32'hCAFE_F00D);
    #1;
    check("inflight_ready", 64'(bus.Req_Ready), 64'(3'b001));
    do_reset("inflight");
    bus.Req_Valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      run_cycle(r);
      check($sformatf("norewrite%0d", k), 64'(bus.WrEn_RF), 64'(0));
    end

    // First grant after reset starts at requester 0.
    bus.Req_Valid = 3'b111;
    set_req(0, 5'd3, 32'h0000_0A00);
    run_cycle(r);
    check("first_after_rst", 64'(r), 64'(3'b001));

    // Requesters 1 and 2 held valid.
    bus.Req_Valid = 3'b110;
    for (int k = 0; k < 6; k++) begin
      run_cycle(r);
      check($sformatf("v110_%0d", k), 64'(r),
            64'(mode_sel((k % 2 == 0) ? 3'b010 : 3'b100, 3'b010)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
